// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the `sub` port and two's-complement subtraction.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              fa_sum, fa_cout;

  fa_cell u_fa_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      carry_q   <= carry_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = b;
          carry_d   = cin;
`ifdef SERIAL_ADDER_SUB_EN
          // a - b computed as a + ~b + 1; cin is ignored when subtracting.
          if (sub) begin
            b_sh_d  = ~b;
            carry_d = 1'b1;
          end
`endif
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        carry_d   = fa_cout;
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        sum_sh_d  = {fa_sum, sum_sh_q[WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + CntW'(1);
        if (bit_cnt_q == LastBit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake flags decode only from the state register.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StShift) || (state_q == StDone);
  assign sum       = sum_sh_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands vs. arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin_in = 1'b0;
  logic         sub_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .cin       (cin_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: {cout, sum} is the (W+1)-bit result of plain integer arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    int unsigned r;
`ifdef SERIAL_ADDER_SUB_EN
    if (s) begin
      r = int'(a) + ((1 << W) - 1 - int'(b)) + 1;
      return r[W:0];
    end
`endif
    r = int'(a) + int'(b) + int'(c);
    if (s) r = r;
    return r[W:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Present operands for one cycle; returns at the negedge after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic s);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a_in = a; b_in = b; cin_in = c; sub_in = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done();
    while (!out_valid && cyc < 4 * W) step();
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic s, input int hold);
    logic [W:0] exp;
    exp = model(a, b, c, s);
    wait_done();
    chk({tag, "_latency"}, cyc, W);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, exp[W-1:0]});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp[W]});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_sum"}, {23'd0, cout, sum}, {23'd0, exp});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_kept_result"}, {23'd0, cout, sum}, {23'd0, exp});
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;

    step();
    step();
    reset = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);

    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    finish_op("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    start_op(8'h55, 8'hAA, 1'b1, 1'b0);
    finish_op("55_aa", 8'h55, 8'hAA, 1'b1, 1'b0, 0);
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    finish_op("12_34", 8'h12, 8'h34, 1'b0, 1'b0, 5);

    // New operands offered mid-shift must be dropped.
    start_op(8'h3C, 8'h21, 1'b1, 1'b0);
    step();
    step();
    a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ignore_busy", {31'd0, busy}, 32'd1);
    finish_op("ignore", 8'h3C, 8'h21, 1'b1, 1'b0, 0);

    // Reset after three shift edges discards the operation.
    start_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_sum", {24'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    start_op(8'h0F, 8'h01, 1'b0, 1'b0);
    finish_op("after_rst", 8'h0F, 8'h01, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    start_op(8'h10, 8'h01, 1'b0, 1'b1);
    finish_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 0);
    start_op(8'h00, 8'h01, 1'b1, 1'b1);
    finish_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      start_op(ra, rb, rc, 1'b0);
      finish_op("rand", ra, rb, rc, 1'b0, i % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
